// File: rtl/pmem_line_adaptor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pmem_line_adaptor: turns one cache line read/write into a 4-beat memory burst.
// Rev 1.0
// ----------------------------------------------------------------------------
module pmem_line_adaptor #(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int OFF_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        address_i,
   input  logic               read_i,
   input  logic               write_i,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   output logic               resp_o,
   output logic [31:0]        address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   input  logic               resp_i
);

   localparam int BEATS = LINE_W / BURST_W;
   localparam int CNT_W = $clog2(BEATS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [LINE_W-1:0]  r_buf;
   logic [LINE_W-1:0]  r_line;
   logic [31:0]        r_addr;
   logic               w_last;
   logic               w_accept;

   assign w_last    = resp_i && (r_cnt == CNT_W'(BEATS - 1));
   assign w_accept  = (r_state == S_IDLE) && (write_i || read_i);
   assign line_o    = r_line;
   assign address_o = r_addr;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      read_o  = 1'b0;
      write_o = 1'b0;
      resp_o  = 1'b0;
      burst_o = '0;
      case (r_state)
         S_IDLE: begin
            // write wins when the cache raises both requests
            if (write_i)     w_next = S_WR;
            else if (read_i) w_next = S_RD;
         end
         S_RD: begin
            read_o = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_WR: begin
            write_o = 1'b1;
            burst_o = r_buf[r_cnt*BURST_W +: BURST_W];
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            resp_o = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_buf  <= '0;
         r_line <= '0;
         r_addr <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= {address_i[31:OFF_W], {OFF_W{1'b0}}};
            r_cnt  <= '0;
            if (write_i) r_buf <= line_i;
         end
         // counter wraps back to zero on the final beat
         if ((r_state == S_RD || r_state == S_WR) && resp_i)
            r_cnt <= r_cnt + 1'b1;
         if (r_state == S_RD && resp_i)
            r_line[r_cnt*BURST_W +: BURST_W] <= burst_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pmem_line_adaptor.sv
`default_nettype none
// Scoreboarded bench for pmem_line_adaptor: directed cases followed by random traffic.
module tb_pmem_line_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  address_i;
   logic         read_i, write_i;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic         resp_o;
   logic [31:0]  address_o;
   logic         read_o, write_o;
   logic [63:0]  burst_i, burst_o;
   logic         resp_i;

   pmem_line_adaptor dut (
      .clk(clk), .rst(rst),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .line_i(line_i),
      .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
      .read_o(read_o), .write_o(write_o),
      .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           wr;
      logic [31:0]  addr;
      logic [255:0] line;
   } exp_t;

   exp_t         sb[$];
   logic [63:0]  beat_q[$];
   logic [63:0]  g_beats[4];
   logic [255:0] m_line;
   int           checks = 0;
   int           errors = 0;

   function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [255:0] rnd256();
      return {rnd64(), rnd64(), rnd64(), rnd64()};
   endfunction

   // Monitor: checks completions, write beats, direction and completion latency.
   int mon_beats = 0;
   bit exp_resp  = 0;
   bit prev_resp = 0;
   always @(negedge clk) begin
      if (rst) begin
         mon_beats = 0;
         exp_resp  = 0;
         prev_resp = 0;
      end else begin
         if (exp_resp) begin
            chk("resp_latency", resp_o, 1);
            exp_resp = 0;
         end
         if (resp_o) begin
            chk("resp_single_cycle", prev_resp, 0);
            chk("done_quiet", {read_o, write_o}, 2'b00);
            if (sb.size() == 0) chk("spurious_resp", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("address_o", address_o, e.addr);
               chk("line_o", line_o, e.line);
            end
         end
         prev_resp = resp_o;
         if ((read_o || write_o) && sb.size() > 0)
            chk("direction", {read_o, write_o}, sb[0].wr ? 2'b01 : 2'b10);
         if (write_o && resp_i) begin
            if (beat_q.size() == 0) chk("unexpected_wbeat", 1, 0);
            else chk("burst_o", burst_o, beat_q.pop_front());
         end
         if ((read_o || write_o) && resp_i) begin
            mon_beats++;
            if (mon_beats == 4) begin
               exp_resp  = 1;
               mon_beats = 0;
            end
         end
      end
   end

   // One cache request; pat/plen give a fixed resp_i pattern, plen==0 means random gaps.
   task automatic run_txn(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [15:0] pat,
                          input int plen, input int abort_after);
      exp_t e;
      int   beats = 0;
      int   step  = 0;
      bit   r;
      bit   take_wr;
      take_wr   = wr;
      read_i    = rd;
      write_i   = wr;
      address_i = addr;
      line_i    = wline;
      resp_i    = 1'b0;
      e.wr   = take_wr;
      e.addr = addr & 32'hFFFF_FFE0;
      if (take_wr) begin
         e.line = m_line;
         for (int k = 0; k < 4; k++) beat_q.push_back(wline[64*k +: 64]);
      end else begin
         for (int k = 0; k < 4; k++) e.line[64*k +: 64] = g_beats[k];
         if (abort_after == 0) m_line = e.line;
      end
      if (abort_after == 0) sb.push_back(e);
      @(posedge clk); #1;
      chk("accept", read_o | write_o, 1);
      while (beats < 4) begin
         if (step > 64) begin
            chk("beat_timeout", 1, 0);
            break;
         end
         chk("busy_dir", take_wr ? write_o : read_o, 1);
         if (abort_after != 0 && beats == abort_after) begin
            rst     = 1'b1;
            read_i  = 1'b0;
            write_i = 1'b0;
            resp_i  = 1'b1;
            burst_i = rnd64();
            @(posedge clk); #1;
            chk("abort_read_o", read_o, 0);
            chk("abort_line_o", line_o, 256'd0);
            chk("abort_resp_o", resp_o, 0);
            chk("abort_address_o", address_o, 32'd0);
            rst    = 1'b0;
            resp_i = 1'b0;
            m_line = '0;
            @(posedge clk); #1;
            return;
         end
         if (plen > 0) r = (step < plen) ? pat[step] : 1'b1;
         else          r = ($urandom % 3) != 0;
         step++;
         resp_i    = r;
         burst_i   = (r && !take_wr) ? g_beats[beats] : rnd64();
         address_i = $urandom;
         line_i    = rnd256();
         @(posedge clk); #1;
         if (r) beats++;
      end
      resp_i = 1'b0;
      @(posedge clk); #1;
      read_i  = 1'b0;
      write_i = 1'b0;
      resp_i  = $urandom % 2;
      burst_i = rnd64();
      @(posedge clk); #1;
      resp_i  = 1'b0;
   endtask

   initial begin
      logic [255:0] wl;
      rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
      address_i = '0; line_i = '0; burst_i = '0; m_line = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_read_o", read_o, 0);
      chk("rst_write_o", write_o, 0);
      chk("rst_resp_o", resp_o, 0);
      chk("rst_address_o", address_o, 0);
      chk("rst_line_o", line_o, 0);
      chk("rst_burst_o", burst_o, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // back-to-back read, no gaps
      g_beats[0] = 64'h1111_1111_1111_1111; g_beats[1] = 64'h2222_2222_2222_2222;
      g_beats[2] = 64'h3333_3333_3333_3333; g_beats[3] = 64'h4444_4444_4444_4444;
      run_txn(0, 1, 32'h0000_1234, '0, 16'h000F, 4, 0);
      chk("t1_address", address_o, 32'h0000_1220);
      chk("t1_line", line_o, {g_beats[3], g_beats[2], g_beats[1], g_beats[0]});

      // read with gaps 1,0,0,1,1,0,1
      for (int k = 0; k < 4; k++) g_beats[k] = rnd64();
      run_txn(0, 1, 32'hABCD_EF1F, '0, 16'b1011001, 7, 0);

      // write A,B,C,D; line_o must keep the previous read
      wl = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
      run_txn(1, 0, 32'h8000_0040, wl, 16'h000F, 4, 0);

      // both requests together: write path
      run_txn(1, 1, 32'h1234_5678, rnd256(), 16'h0, 0, 0);

      // reset after beat 2 of a read, then a fresh read
      for (int k = 0; k < 4; k++) g_beats[k] = rnd64();
      run_txn(0, 1, 32'h0000_F000, '0, 16'h0, 0, 2);
      for (int k = 0; k < 4; k++) g_beats[k] = rnd64();
      run_txn(0, 1, 32'h0000_F004, '0, 16'h0, 0, 0);

      // write then read back-to-back
      run_txn(1, 0, 32'h4444_0000, rnd256(), 16'h0, 0, 0);
      for (int k = 0; k < 4; k++) g_beats[k] = rnd64();
      run_txn(0, 1, 32'h4444_0020, '0, 16'h0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         int kind;
         kind = $urandom % 5;
         for (int k = 0; k < 4; k++) g_beats[k] = rnd64();
         run_txn(kind >= 3, kind != 3, $urandom, rnd256(), 16'h0, 0, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      chk("wbeats_drained", beat_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
